imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous instruction memory between the fetch stage (read-only) and the host
//  program loader (read/write). Round-robin arbitration when both request. A lock sequence (RUN->DRAIN->LOCKED)
//  gives the loader exclusive access while a program is written. Drives stall_f for the fetch stage.
//  Sits between Fetch/InstructionCache and the memory macro.
// PARAMETERS
//  MEM_ADDR_BITS  10  word-address width of the memory (1024 x 32-bit words)
//  DATA_WIDTH     32  memory word width
// PORTS
//  clk           in   1    clock, all state on rising edge
//  reset         in   1    asynchronous, active-high reset
//  fetch_req     in   1    fetch read request, held until granted
//  fetch_addr    in   32   byte address (pc_f)
//  fetch_gnt     out  1    fetch request accepted this cycle
//  fetch_rvalid  out  1    fetch_rdata valid (1 cycle after grant)
//  fetch_rdata   out  32   instruction word
//  fetch_err     out  1    misaligned fetch, pulses with fetch_rvalid
//  stall_f       out  1    fetch_req & !fetch_gnt
//  load_req      in   1    loader request, held until granted
//  load_we       in   1    1 = write, 0 = read
//  load_addr     in   MEM_ADDR_BITS  word address
//  load_wdata    in   32   write data
//  load_gnt      out  1    loader request accepted this cycle
//  load_rvalid   out  1    load_rdata valid (1 cycle after read grant)
//  load_rdata    out  32   read data
//  load_lock     in   1    level: request exclusive access
//  locked        out  1    state == LOCKED
//  mem_en, mem_we  out 1   memory enable / write enable
//  mem_addr      out  MEM_ADDR_BITS  word address
//  mem_wdata     out  32   memory write data
//  mem_rdata     in   32   memory read data, valid 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Reset (async): state=RUN, last_gnt=LOADER (fetch wins first tie), rvalid pipe cleared, locked=0.
//    All gnt/rvalid/err/mem_en/mem_we outputs are 0. An outstanding read in flight at reset is dropped
//    and never returned.
//  - Grants are combinational from req, state and last_gnt. At most one grant per cycle; mem_* is driven
//    from the granted requester in the same cycle.
//  - RUN: only one requester active -> it is granted. Both active -> the one != last_gnt is granted.
//    last_gnt updates on each grant.
//  - Fetch word address = fetch_addr[MEM_ADDR_BITS+1:2]; upper bits ignored (wrap).
//    fetch_addr[1:0]!=0 -> still read; fetch_err=1 alongside fetch_rvalid.
//  - Read latency is exactly 1 cycle. A registered owner tag routes mem_rdata to fetch_rdata or load_rdata.
//    The rdata of a non-owner is don't-care (drive 0). Loader writes produce no rvalid.
//  - Back-to-back grants allowed every cycle (throughput 1 access/cycle).
//  - State machine:
//    * RUN -> DRAIN when load_lock=1. Fetch grants stop in the same cycle load_lock is seen.
//    * DRAIN: loader may be granted. -> LOCKED when no fetch read is in flight. This takes at most 1 cycle,
//      and 0 extra cycles if none was in flight: DRAIN->LOCKED on the next edge.
//    * LOCKED: loader only; fetch_gnt=0 (stall_f follows fetch_req). -> RUN when load_lock=0.
//    * DRAIN with load_lock=0 -> RUN.
//  - Write-then-read to the same address on consecutive cycles returns the new data (memory is read-after-write).
//  - Simultaneous load_lock rise and fetch-only request: fetch is not granted that cycle.
// STRUCTURE
//  - imem_pkg: typedef enum logic [1:0] {ARB_RUN, ARB_DRAIN, ARB_LOCKED} arb_state_t;
//    typedef enum logic {OWN_FETCH, OWN_LOADER} arb_owner_t.
//  - No sub-module: one always_ff (state, last_gnt, rvalid/owner/err pipe) plus one always_comb (grant, mem mux).
// TESTING
//  1. Reset, then fetch_req=1 with addr 0x0,0x4,0x8 on consecutive cycles, loader idle.
//     -> fetch_gnt every cycle; rdata = mem[0],mem[1],mem[2] one cycle later; stall_f=0.
//  2. fetch_req and load_req (read, addr 5) held together for 4 cycles.
//     -> grants alternate F,L,F,L; rvalid routed correctly; stall_f=1 on loader cycles.
//  3. load_lock=1 while a fetch read is in flight. -> DRAIN for 1 cycle, then locked=1; fetch_rvalid still
//     returns; loader writes 0xDEADBEEF to addr 3; drop lock. -> RUN next cycle; fetch of 0xC returns 0xDEADBEEF.
//  4. fetch_addr=0x6. -> fetch_rvalid=1 with fetch_err=1 and rdata=mem[1].
//     fetch_addr=0x1000 with MEM_ADDR_BITS=10. -> reads mem[0].
//  5. Assert reset while a loader read is in flight. -> load_rvalid stays 0, all outputs 0, state RUN;
//     after release, fetch wins the first tie.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types for the instruction memory port arbiter
package imem_pkg;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_DRAIN,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_LOADER
  } arb_owner_t;

endpackage

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares one sync instruction memory between fetch and the program loader
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 10,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_gnt,
  output logic                     fetch_rvalid,
  output logic [DATA_WIDTH-1:0]    fetch_rdata,
  output logic                     fetch_err,
  output logic                     stall_f,
  input  logic                     load_req,
  input  logic                     load_we,
  input  logic [MEM_ADDR_BITS-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]    load_wdata,
  output logic                     load_gnt,
  output logic                     load_rvalid,
  output logic [DATA_WIDTH-1:0]    load_rdata,
  input  logic                     load_lock,
  output logic                     locked,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  arb_state_t state_q, state_d;
  arb_owner_t last_gnt_q, last_gnt_d;
  arb_owner_t owner_q, owner_d;
  logic       rvalid_q, rvalid_d;
  logic       err_q, err_d;
  logic       fetch_cand, load_cand, fetch_inflight;

  // Upper fetch address bits deliberately wrap onto the memory.
  logic unused_fetch_hi;
  assign unused_fetch_hi = ^fetch_addr[31:MEM_ADDR_BITS+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_RUN;
      last_gnt_q <= OWN_LOADER;
      owner_q    <= OWN_FETCH;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    fetch_gnt  = 1'b0;
    load_gnt   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;

    // Fetch is fenced off the moment load_lock is seen, even before DRAIN.
    fetch_cand     = fetch_req && !reset && (state_q == ARB_RUN) && !load_lock;
    load_cand      = load_req && !reset;
    fetch_inflight = rvalid_q && (owner_q == OWN_FETCH);

    if (fetch_cand && load_cand) begin
      fetch_gnt = (last_gnt_q == OWN_LOADER);
      load_gnt  = (last_gnt_q == OWN_FETCH);
    end else begin
      fetch_gnt = fetch_cand;
      load_gnt  = load_cand;
    end

    if (fetch_gnt) begin
      mem_en     = 1'b1;
      mem_addr   = fetch_addr[MEM_ADDR_BITS+1:2];
      last_gnt_d = OWN_FETCH;
      owner_d    = OWN_FETCH;
      rvalid_d   = 1'b1;
      err_d      = |fetch_addr[1:0];
    end else if (load_gnt) begin
      mem_en     = 1'b1;
      mem_we     = load_we;
      mem_addr   = load_addr;
      mem_wdata  = load_wdata;
      last_gnt_d = OWN_LOADER;
      owner_d    = OWN_LOADER;
      rvalid_d   = !load_we;
    end

    unique case (state_q)
      ARB_RUN:    if (load_lock) state_d = ARB_DRAIN;
      ARB_DRAIN: begin
        if (!load_lock)           state_d = ARB_RUN;
        else if (!fetch_inflight) state_d = ARB_LOCKED;
      end
      ARB_LOCKED: if (!load_lock) state_d = ARB_RUN;
      default:    state_d = ARB_RUN;
    endcase
  end

  assign stall_f      = fetch_req && !fetch_gnt;
  assign fetch_rvalid = fetch_inflight;
  assign fetch_err    = fetch_inflight && err_q;
  assign fetch_rdata  = fetch_inflight ? mem_rdata : '0;
  assign load_rvalid  = rvalid_q && (owner_q == OWN_LOADER);
  assign load_rdata   = load_rvalid ? mem_rdata : '0;
  assign locked       = (state_q == ARB_LOCKED);

endmodule
